// File: rtl/window_cache_pingpong_if.sv
// Window-cache bus: loader write port, core element-read port, and scheduler status.
// The cache side uses the slave modport; loader/core/testbench drive through master.
interface window_cache_pingpong_if #(
   parameter int WINDOW_BLOCKING = 4,
   parameter int ELEM_W          = 32,
   parameter int WIN_Y_W         = 5,
   parameter int WIN_BLOCK_W     = 3
);
   localparam int X_W = WIN_BLOCK_W + $clog2(WINDOW_BLOCKING);

   logic                              wr_we;
   logic [WIN_Y_W-1:0]                wr_y;
   logic [WIN_BLOCK_W-1:0]            wr_block;
   logic [WINDOW_BLOCKING*ELEM_W-1:0] wr_data;
   logic                              wr_commit;
   logic                              wr_ready;
   logic                              rd_req;
   logic [WIN_Y_W-1:0]                rd_y;
   logic [X_W-1:0]                    rd_x;
   logic                              rd_release;
   logic                              rd_win_ready;
   logic                              rd_valid;
   logic [ELEM_W-1:0]                 rd_data;
   logic                              err_overflow;
   logic                              err_underflow;

   modport master (
      output wr_we, wr_y, wr_block, wr_data, wr_commit, rd_req, rd_y, rd_x, rd_release,
      input  wr_ready, rd_win_ready, rd_valid, rd_data, err_overflow, err_underflow
   );

   modport slave (
      input  wr_we, wr_y, wr_block, wr_data, wr_commit, rd_req, rd_y, rd_x, rd_release,
      output wr_ready, rd_win_ready, rd_valid, rd_data, err_overflow, err_underflow
   );
endinterface

// File: rtl/window_cache_pingpong.sv
// Ping-pong window store between the loader (block writes) and the Haar core (element reads).
// Define WINDOW_CACHE_DOUBLE_BUF_EN for two banks; otherwise a single bank with capacity one.
module window_cache_pingpong #(
   parameter int WINDOW_BLOCKING = 4,
   parameter int ELEM_W          = 32,
   parameter int WIN_Y_W         = 5,
   parameter int WIN_BLOCK_W     = 3
) (
   input  logic                    clk,
   input  logic                    resetn,
   window_cache_pingpong_if.slave  bus
);
   localparam int EL_W   = $clog2(WINDOW_BLOCKING);
   localparam int X_W    = WIN_BLOCK_W + EL_W;
   localparam int BLK_W  = WINDOW_BLOCKING * ELEM_W;
`ifdef WINDOW_CACHE_DOUBLE_BUF_EN
   localparam int ADDR_W = 1 + WIN_Y_W + WIN_BLOCK_W;
   localparam logic [1:0] CAP = 2'd2;
`else
   localparam int ADDR_W = WIN_Y_W + WIN_BLOCK_W;
   localparam logic [1:0] CAP = 2'd1;
`endif

   logic              wp_q, wp_d, rp_q, rp_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              ovf_q, ovf_d, udf_q, udf_d;
   logic              wr_ready, win_ready, commit_ok, release_ok;
   logic [ADDR_W-1:0] wr_addr, rd_addr;
   logic [BLK_W-1:0]  mem [2**ADDR_W];
   logic [BLK_W-1:0]  rd_word_q;
   logic [EL_W-1:0]   elem_q;
   logic [1:0]        vld_pipe_q;
   logic [ELEM_W-1:0] rd_data_q;

   assign wr_ready   = cnt_q < CAP;
   assign win_ready  = cnt_q != 2'd0;
   assign commit_ok  = bus.wr_commit & wr_ready;
   assign release_ok = bus.rd_release & win_ready;

`ifdef WINDOW_CACHE_DOUBLE_BUF_EN
   assign wr_addr = {wp_q, bus.wr_y, bus.wr_block};
   assign rd_addr = {rp_q, bus.rd_y, bus.rd_x[X_W-1:EL_W]};
`else
   assign wr_addr = {bus.wr_y, bus.wr_block};
   assign rd_addr = {bus.rd_y, bus.rd_x[X_W-1:EL_W]};
`endif

   // Commit is judged against pre-release occupancy, so commit+release while full still rejects.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      udf_d = udf_q;
      if (commit_ok)  cnt_d = cnt_d + 2'd1;
      if (release_ok) cnt_d = cnt_d - 2'd1;
`ifdef WINDOW_CACHE_DOUBLE_BUF_EN
      if (commit_ok)  wp_d = ~wp_q;
      if (release_ok) rp_d = ~rp_q;
`endif
      if ((bus.wr_we | bus.wr_commit) & ~wr_ready)   ovf_d = 1'b1;
      if ((bus.rd_req | bus.rd_release) & ~win_ready) udf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         cnt_q      <= 2'd0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
         vld_pipe_q <= 2'b00;
         elem_q     <= '0;
         rd_data_q  <= '0;
      end else begin
         wp_q       <= wp_d;
         rp_q       <= rp_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
         vld_pipe_q <= {vld_pipe_q[0], bus.rd_req};
         if (bus.rd_req)    elem_q    <= bus.rd_x[EL_W-1:0];
         if (vld_pipe_q[0]) rd_data_q <= rd_word_q[elem_q*ELEM_W +: ELEM_W];
      end
   end

   // Storage is not reset; a read in the same cycle as a write to that block sees the old word.
   always_ff @(posedge clk) begin
      if (resetn && bus.wr_we && wr_ready) mem[wr_addr] <= bus.wr_data;
      if (bus.rd_req) rd_word_q <= mem[rd_addr];
   end

   assign bus.wr_ready      = wr_ready;
   assign bus.rd_win_ready  = win_ready;
   assign bus.rd_valid      = vld_pipe_q[1];
   assign bus.rd_data       = rd_data_q;
   assign bus.err_overflow  = ovf_q;
   assign bus.err_underflow = udf_q;
endmodule

// File: tb/tb_window_cache_pingpong.sv
// Randomized bench for window_cache_pingpong with an element-level occupancy/bank model.
module tb_window_cache_pingpong;
   localparam int WB = 4, EW = 32, YW = 5, BW = 3;
`ifdef WINDOW_CACHE_DOUBLE_BUF_EN
   localparam int CAP = 2, DB = 1;
`else
   localparam int CAP = 1, DB = 0;
`endif

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   window_cache_pingpong_if #(.WINDOW_BLOCKING(WB), .ELEM_W(EW), .WIN_Y_W(YW), .WIN_BLOCK_W(BW)) bus ();
   window_cache_pingpong #(.WINDOW_BLOCKING(WB), .ELEM_W(EW), .WIN_Y_W(YW), .WIN_BLOCK_W(BW))
      dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

   int nchk = 0, nerr = 0, cyc = 0;
   bit chk_en = 0;

   // model: element-addressed banks, occupancy, pointers, pending reads by due edge
   int unsigned mm [2][32][32];
   bit          mk [2][32][32];
   int cnt = 0, wp = 0, rp = 0;
   bit ovf = 0, udf = 0;
   typedef struct { int due; int unsigned d; bit k; } rd_t;
   rd_t rq[$];
   bit e_valid = 0, e_known = 1;
   int unsigned e_data = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_edge();
      bit c_ok, r_ok, rdy;
      logic [127:0] d;
      rd_t r;
      if (!resetn) begin
         cnt = 0; wp = 0; rp = 0; ovf = 0; udf = 0;
         rq.delete();
         e_valid = 0; e_data = 0; e_known = 1;
         return;
      end
      e_valid = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         e_valid = 1; e_data = r.d; e_known = r.k;
      end
      if (bus.rd_req) begin
         r.due = cyc + 1;
         r.d   = mm[rp][bus.rd_y][bus.rd_x];
         r.k   = mk[rp][bus.rd_y][bus.rd_x];
         rq.push_back(r);
         if (cnt == 0) udf = 1;
      end
      rdy = (cnt < CAP);
      if (bus.wr_we) begin
         if (rdy) begin
            d = bus.wr_data;
            for (int e = 0; e < WB; e++) begin
               mm[wp][bus.wr_y][bus.wr_block*WB+e] = d[e*32 +: 32];
               mk[wp][bus.wr_y][bus.wr_block*WB+e] = 1;
            end
         end else ovf = 1;
      end
      c_ok = bus.wr_commit && rdy;
      if (bus.wr_commit && !rdy) ovf = 1;
      r_ok = bus.rd_release && cnt != 0;
      if (bus.rd_release && cnt == 0) udf = 1;
      if (c_ok) begin cnt++; wp = wp ^ DB; end
      if (r_ok) begin cnt--; rp = rp ^ DB; end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("wr_ready", bus.wr_ready, cnt < CAP);
         chk("rd_win_ready", bus.rd_win_ready, cnt != 0);
         chk("rd_valid", bus.rd_valid, e_valid);
         chk("err_overflow", bus.err_overflow, ovf);
         chk("err_underflow", bus.err_underflow, udf);
         if (e_known) chk("rd_data", bus.rd_data, e_data);
      end
   end

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic idle();
      bus.wr_we = 0; bus.wr_commit = 0; bus.rd_req = 0; bus.rd_release = 0;
   endtask

   task automatic do_reset();
      idle();
      resetn = 0; step(); step(); resetn = 1;
   endtask

   task automatic write_blk(input int y, input int b, input int base);
      logic [127:0] d;
      for (int e = 0; e < WB; e++) d[e*32 +: 32] = 32'(base + e);
      bus.wr_we = 1; bus.wr_y = 5'(y); bus.wr_block = 3'(b); bus.wr_data = d;
      step();
      bus.wr_we = 0;
   endtask

   task automatic pulse_commit();
      bus.wr_commit = 1; step(); bus.wr_commit = 0;
   endtask

   task automatic pulse_release();
      bus.rd_release = 1; step(); bus.rd_release = 0;
   endtask

   task automatic read(input int y, input int x);
      bus.rd_req = 1; bus.rd_y = 5'(y); bus.rd_x = 5'(x); step(); bus.rd_req = 0;
   endtask

   initial begin
      idle();
      bus.wr_y = 0; bus.wr_block = 0; bus.wr_data = '0; bus.rd_y = 0; bus.rd_x = 0;
      step();
      chk_en = 1;
      do_reset();
      chk("rst_wr_ready", bus.wr_ready, 1);
      chk("rst_rd_win_ready", bus.rd_win_ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_err_overflow", bus.err_overflow, 0);
      chk("rst_err_underflow", bus.err_underflow, 0);

      pulse_release();
      chk("rel_empty_udf", bus.err_underflow, 1);
      chk("rel_empty_win_ready", bus.rd_win_ready, 0);
      do_reset();
      read(0, 0);
      step();
      chk("rd_empty_valid", bus.rd_valid, 1);
      chk("rd_empty_udf", bus.err_underflow, 1);
      chk("rd_empty_win_ready", bus.rd_win_ready, 0);
      do_reset();

      for (int y = 0; y < 24; y++)
         for (int b = 0; b < 6; b++) write_blk(y, b, y*100 + b*4);
      chk("pre_commit_wr_ready", bus.wr_ready, 1);
      pulse_commit();
      chk("commit_win_ready", bus.rd_win_ready, 1);
      read(3, 9);
      chk("lat_not_yet", bus.rd_valid, 0);
      step();
      chk("rd_3_9_valid", bus.rd_valid, 1);
      chk("rd_3_9_data", bus.rd_data, 309);

`ifdef WINDOW_CACHE_DOUBLE_BUF_EN
      write_blk(0, 0, 7000);
      pulse_commit();
      chk("two_full_wr_ready", bus.wr_ready, 0);
      pulse_commit();
      chk("third_commit_ovf", bus.err_overflow, 1);
      chk("third_commit_win_ready", bus.rd_win_ready, 1);
      pulse_release();
      read(0, 0);
      step();
      chk("rd_bank_b", bus.rd_data, 7000);
      write_blk(0, 0, 8000);
      bus.wr_commit = 1; bus.rd_release = 1; step(); idle();
      chk("cr_win_ready", bus.rd_win_ready, 1);
      chk("cr_wr_ready", bus.wr_ready, 1);
      read(0, 0);
      step();
      chk("cr_rp_toggled", bus.rd_data, 8000);
`else
      chk("single_full_wr_ready", bus.wr_ready, 0);
      pulse_commit();
      chk("single_second_commit_ovf", bus.err_overflow, 1);
      pulse_release();
      chk("single_release_wr_ready", bus.wr_ready, 1);
      pulse_commit();
      chk("single_recommit_wr_ready", bus.wr_ready, 0);
`endif

      for (int k = 0; k < 8; k++) begin
         bus.rd_req = 1; bus.rd_y = 5'd5; bus.rd_x = 5'(k);
         bus.rd_release = (k == 2);
         step();
         if (k >= 1 && k <= 3) chk("row5_old_bank", bus.rd_data, 32'(500 + k - 1));
      end
      idle();
      step(); step();

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         resetn        = ($urandom_range(0, 199) != 0);
         bus.wr_we     = ($urandom_range(0, 2) == 0);
         bus.wr_y      = 5'($urandom_range(0, 31));
         bus.wr_block  = 3'($urandom_range(0, 7));
         bus.wr_data   = {$urandom, $urandom, $urandom, $urandom};
         bus.wr_commit = ($urandom_range(0, 7) == 0);
         bus.rd_release = ($urandom_range(0, 7) == 0);
         bus.rd_req    = ($urandom_range(0, 1) == 0);
         bus.rd_y      = 5'($urandom_range(0, 31));
         bus.rd_x      = 5'($urandom_range(0, 31));
         step();
      end
      idle();
      resetn = 1;
      step(); step(); step();
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
